// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if
//   Bundles the sample tick, key events, datapath flags and the datapath
//   control/status outputs of the voice scheduler.
//   master : sequencer host / datapath side (drives tick, events, flags)
//   slave  : voice_scheduler (drives KEY, load enables, selects, status)
interface voice_scheduler_if;
  logic       SAMPLE_TICK;
  logic       EVT_VALID;
  logic [6:0] EVT_KEY;
  logic       EVT_ON;
  logic       ATT_OFF;
  logic       NOTE_END;

  logic [6:0] KEY;
  logic       LD_PHASE;
  logic       LD_AMP;
  logic       LD_TONE;
  logic       PHASE_MUX;
  logic       TONE_MUX;
  logic       AMP_SEL;
  logic       NOTE_ON;
  logic       ATT_ON;
  logic       SAMPLE_VALID;
  logic       BUSY;
  logic [7:0] VOICES;
  logic       OVERRUN;

  modport master (
    output SAMPLE_TICK, EVT_VALID, EVT_KEY, EVT_ON, ATT_OFF, NOTE_END,
    input  KEY, LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL,
           NOTE_ON, ATT_ON, SAMPLE_VALID, BUSY, VOICES, OVERRUN
  );

  modport slave (
    input  SAMPLE_TICK, EVT_VALID, EVT_KEY, EVT_ON, ATT_OFF, NOTE_END,
    output KEY, LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL,
           NOTE_ON, ATT_ON, SAMPLE_VALID, BUSY, VOICES, OVERRUN
  );
endinterface

// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Per-sample sequencer for the 128-voice synth datapath. Each sample tick
//   clears the tone accumulator, sweeps KEY 0..127 (one key per clock) driving
//   the phase/amplitude/tone loads, tracks each key's envelope state and
//   strobes SAMPLE_VALID when the mix is complete.
//   Ports:
//     CLK   - system clock
//     RESET - synchronous, active-high
//     bus   - voice_scheduler_if.slave (tick, events, datapath flags in;
//             KEY, load enables, mux selects, envelope and status out)
//
//   state  | meaning
//   WAIT   | idle, waiting for a tick (new or pending)
//   CLEAR  | clear datapath TONE accumulator
//   SCAN   | present KEY = scan counter, update its envelope
//   DONE   | SAMPLE_VALID pulse, VOICES published
module voice_scheduler (
  input  logic               CLK,
  input  logic               RESET,
  voice_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {S_WAIT, S_CLEAR, S_SCAN, S_DONE} state_t;
  typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_HELD, ENV_RELEASE} env_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] voices_q, voices_d;
  logic       pend_q, pend_d;
  logic       ovr_q, ovr_d;
  logic [1:0] env_q [128];

  logic       scan_en;
  logic [1:0] cur_env;
  logic       cur_active;
  logic [1:0] scan_nxt;
  logic [1:0] evt_env;
  logic [1:0] evt_nxt;
  logic       evt_wr;

  assign scan_en    = (state_q == S_SCAN);
  assign cur_env    = env_q[cnt_q];
  assign cur_active = (cur_env != ENV_IDLE);

  // Envelope advance for the key currently being scanned.
  always_comb begin
    scan_nxt = cur_env;
    if (cur_env == ENV_ATTACK && bus.ATT_OFF)
      scan_nxt = ENV_HELD;
    else if ((cur_env == ENV_HELD || cur_env == ENV_RELEASE) && bus.NOTE_END)
      scan_nxt = ENV_IDLE;
  end

  // Key events. A release on an IDLE/RELEASE key writes nothing, so it does
  // not mask a scan update on the same key.
  assign evt_env = env_q[bus.EVT_KEY];

  always_comb begin
    evt_nxt = evt_env;
    evt_wr  = 1'b0;
    if (bus.EVT_VALID) begin
      if (bus.EVT_ON) begin
        evt_nxt = ENV_ATTACK;
        evt_wr  = 1'b1;
      end else if (evt_env == ENV_ATTACK || evt_env == ENV_HELD) begin
        evt_nxt = ENV_RELEASE;
        evt_wr  = 1'b1;
      end
    end
  end

  // Event write is issued last so it overrides a same-key scan update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 128; i++) env_q[i] <= ENV_IDLE;
    end else begin
      if (scan_en) env_q[cnt_q] <= scan_nxt;
      if (evt_wr)  env_q[bus.EVT_KEY] <= evt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      acc_q    <= '0;
      voices_q <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      voices_q <= voices_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    voices_d = voices_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    case (state_q)
      S_WAIT: begin
        if (bus.SAMPLE_TICK || pend_q) begin
          state_d = S_CLEAR;
          pend_d  = 1'b0;
          // A fresh tick arriving as the pending one is consumed is lost.
          if (bus.SAMPLE_TICK && pend_q) ovr_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_SCAN;
        cnt_d   = '0;
        acc_d   = '0;
      end
      S_SCAN: begin
        acc_d = acc_q + {7'd0, cur_active};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          state_d  = S_DONE;
          voices_d = acc_q + {7'd0, cur_active};
        end
      end
      S_DONE: begin
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
    if (state_q != S_WAIT && bus.SAMPLE_TICK) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_comb begin
    bus.KEY          = '0;
    bus.LD_PHASE     = 1'b0;
    bus.LD_AMP       = 1'b0;
    bus.LD_TONE      = 1'b0;
    bus.PHASE_MUX    = 1'b0;
    bus.TONE_MUX     = 1'b0;
    bus.AMP_SEL      = 1'b0;
    bus.NOTE_ON      = 1'b0;
    bus.ATT_ON       = 1'b0;
    bus.SAMPLE_VALID = (state_q == S_DONE);
    bus.BUSY         = (state_q != S_WAIT);
    bus.VOICES       = voices_q;
    bus.OVERRUN      = ovr_q;
    case (state_q)
      S_CLEAR: begin
        bus.LD_TONE = 1'b1;
      end
      S_SCAN: begin
        bus.KEY      = cnt_q;
        bus.LD_PHASE = 1'b1;
        bus.LD_AMP   = 1'b1;
        if (cur_active) begin
          bus.PHASE_MUX = 1'b1;
          bus.LD_TONE   = 1'b1;
          bus.TONE_MUX  = 1'b1;
          bus.ATT_ON    = (cur_env == ENV_ATTACK);
          bus.NOTE_ON   = (cur_env == ENV_ATTACK) || (cur_env == ENV_HELD);
        end else begin
          bus.AMP_SEL = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [1:0] exp_st [128];

  localparam logic [16:0] CLEAR_V = 17'b0000000_001_000_00_01;
  localparam logic [16:0] DONE_V  = 17'b0000000_000_000_00_11;

  voice_scheduler_if bus ();

  voice_scheduler dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [16:0] outs();
    return {bus.KEY, bus.LD_PHASE, bus.LD_AMP, bus.LD_TONE, bus.PHASE_MUX,
            bus.TONE_MUX, bus.AMP_SEL, bus.NOTE_ON, bus.ATT_ON,
            bus.SAMPLE_VALID, bus.BUSY};
  endfunction

  function automatic logic [16:0] exp_scan(input int k, input logic [1:0] s);
    logic act;
    logic [6:0] kk;
    act = (s != 2'd0);
    kk  = k[6:0];
    return {kk, 1'b1, 1'b1, act, act, act, ~act,
            (s == 2'd1 || s == 2'd2), (s == 2'd1), 1'b0, 1'b1};
  endfunction

  task automatic pulse();
    bus.SAMPLE_TICK = 1'b1;
    step();
    bus.SAMPLE_TICK = 1'b0;
  endtask

  task automatic evt(input int k, input logic on);
    bus.EVT_VALID = 1'b1;
    bus.EVT_KEY   = k[6:0];
    bus.EVT_ON    = on;
    step();
    bus.EVT_VALID = 1'b0;
  endtask

  // One full sweep checked key by key against exp_st; optionally drives
  // ATT_OFF / NOTE_END / a press-or-release event while a given key is shown.
  task automatic sweep(input string tag, input int att_key, input int note_key,
                       input int ev_key, input logic ev_on);
    int nv = 0;
    for (int i = 0; i < 128; i++) if (exp_st[i] != 2'd0) nv++;
    pulse();
    chk({tag, ":clear"}, outs(), CLEAR_V);
    for (int k = 0; k < 128; k++) begin
      step();
      chk($sformatf("%s:key%0d", tag, k), outs(), exp_scan(k, exp_st[k]));
      bus.ATT_OFF   = (k == att_key);
      bus.NOTE_END  = (k == note_key);
      bus.EVT_VALID = (k == ev_key);
      bus.EVT_KEY   = k[6:0];
      bus.EVT_ON    = ev_on;
    end
    step();
    bus.ATT_OFF   = 1'b0;
    bus.NOTE_END  = 1'b0;
    bus.EVT_VALID = 1'b0;
    chk({tag, ":done"}, outs(), DONE_V);
    chk({tag, ":voices"}, bus.VOICES, nv);
    step();
    chk({tag, ":wait"}, outs(), 17'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.BUSY && n < 400) begin
      step();
      n++;
    end
    chk(tag, bus.BUSY, 1'b0);
  endtask

  initial begin
    int c0;
    int n;
    int sv;
    bus.SAMPLE_TICK = 1'b0;
    bus.EVT_VALID   = 1'b0;
    bus.EVT_KEY     = '0;
    bus.EVT_ON      = 1'b0;
    bus.ATT_OFF     = 1'b0;
    bus.NOTE_END    = 1'b0;
    for (int i = 0; i < 128; i++) exp_st[i] = 2'd0;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_outs", outs(), 17'd0);
    chk("rst_voices", bus.VOICES, 8'd0);
    chk("rst_ovr", bus.OVERRUN, 1'b0);
    rst = 1'b0;
    step();

    // empty sweep
    sweep("empty", -1, -1, -1, 1'b0);

    // press 60, attack -> held
    evt(60, 1'b1);
    exp_st[60] = 2'd1;
    sweep("att1", -1, -1, -1, 1'b0);
    sweep("att2", 60, -1, -1, 1'b0);
    exp_st[60] = 2'd2;
    sweep("held", -1, -1, -1, 1'b0);

    // release 60, then note end -> idle
    evt(60, 1'b0);
    exp_st[60] = 2'd3;
    sweep("rel", -1, 60, -1, 1'b0);
    exp_st[60] = 2'd0;
    sweep("idle60", -1, -1, -1, 1'b0);

    // press on key 5 collides with its ATT_OFF scan update: press wins
    evt(5, 1'b1);
    exp_st[5] = 2'd1;
    sweep("coll1", 5, -1, 5, 1'b1);
    sweep("coll2", -1, -1, -1, 1'b0);

    // tick at t and t+50: second CLEAR at t+132, no overrun
    pulse();
    c0 = cyc;
    repeat (49) step();
    pulse();
    n = 0;
    while (!(bus.BUSY && bus.LD_TONE && !bus.TONE_MUX) && n < 300) begin
      step();
      n++;
    end
    chk("q_clear_cyc", cyc - c0, 131);
    chk("q_no_ovr", bus.OVERRUN, 1'b0);
    wait_idle("q_idle");

    // ticks at t, t+50, t+60: overrun, sticky until reset
    pulse();
    repeat (49) step();
    pulse();
    repeat (9) step();
    pulse();
    chk("ovr_set", bus.OVERRUN, 1'b1);
    wait_idle("ovr_idle");
    repeat (5) step();
    chk("ovr_sticky", bus.OVERRUN, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovr_rst", bus.OVERRUN, 1'b0);
    for (int i = 0; i < 128; i++) exp_st[i] = 2'd0;
    step();

    // reset mid-sweep at KEY=70 with keys 10 and 70 active
    evt(10, 1'b1);
    evt(70, 1'b1);
    pulse();
    repeat (71) step();
    chk("mid_key70", outs(), exp_scan(70, 2'd1));
    rst = 1'b1;
    step();
    chk("mid_rst_outs", outs(), 17'd0);
    chk("mid_rst_voices", bus.VOICES, 8'd0);
    rst = 1'b0;
    sv = 0;
    repeat (140) begin
      step();
      if (bus.SAMPLE_VALID) sv++;
    end
    chk("mid_no_sv", sv, 0);
    sweep("post_rst", -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
